// File: rtl/inst_mem_seq.sv
// ---------------------------------------------------------------------------
// inst_mem_seq
//
// Loadable instruction memory with a valid/ready fetch port. Each fetch
// returns one 32-bit word. The number of wait states between accepting a
// request and capturing the word is set by a parameter. Misaligned or
// out-of-range fetches return NOP_INST with error flags and never read the
// array. A program loader can write words in any state. The block also
// counts completed response handshakes.
//
// Parameters
//   DEPTH_LOG2   log2 of the word count (array holds 2**DEPTH_LOG2 x 32 bit)
//   WAIT_STATES  extra cycles between fetch accept and word capture (0..15)
//   NOP_INST     word returned for a faulting fetch
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   req_valid    fetch request valid            (in)
//   req_ready    fetch request accepted now     (out, combinational)
//   req_addr     fetch byte address (PC)        (in, 32)
//   resp_valid   response valid                 (out)
//   resp_ready   consumer takes response        (in)
//   resp_inst    fetched word                   (out, 32)
//   resp_err     bit0 misaligned, bit1 out of range (out, 2)
//   ld_en        loader write strobe            (in)
//   ld_addr      loader byte address            (in, 32)
//   ld_data      loader write data              (in, 32)
//   ld_err       one-cycle pulse after a rejected load (out)
//   fetch_cnt    completed response handshakes  (out, 32, wraps)
// ---------------------------------------------------------------------------
module inst_mem_seq #(
    parameter int          DEPTH_LOG2  = 5,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] NOP_INST    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic [1:0]  resp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_err,
    output logic [31:0] fetch_cnt
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Array has no reset: program contents survive a reset of the control.
    logic [31:0] ram [DEPTH];

    state_t                  state_reg, state_next;
    logic [3:0]              wait_cnt_reg, wait_cnt_next;
    logic [DEPTH_LOG2-1:0]   idx_reg, idx_next;
    logic [31:0]             inst_reg, inst_next;
    logic [1:0]              err_reg, err_next;
    logic                    ld_err_reg;
    logic [31:0]             fetch_cnt_reg;

    // ---------------------------------------------------------------------
    // Address decode for the fetch and loader ports
    // ---------------------------------------------------------------------
    logic [DEPTH_LOG2-1:0] req_idx, ld_idx, rd_idx;
    logic                  req_mis, req_oor;
    logic                  ld_mis, ld_oor;
    logic [1:0]            req_fault;
    logic                  ld_wr;
    logic                  accept;
    logic [31:0]           rd_word;

    assign req_idx   = req_addr[DEPTH_LOG2+1:2];
    assign ld_idx    = ld_addr[DEPTH_LOG2+1:2];
    assign req_mis   = (req_addr[1:0] != 2'b00);
    assign ld_mis    = (ld_addr[1:0] != 2'b00);
    // Any address bit above the word index makes the access out of range.
    assign req_oor   = ((req_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign ld_oor    = ((ld_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign req_fault = {req_oor, req_mis};
    assign ld_wr     = ld_en & ~ld_mis & ~ld_oor;

    assign req_ready = (state_reg == S_IDLE) |
                       ((state_reg == S_RESP) & resp_ready);
    assign accept    = req_valid & req_ready;

    // The word is captured either on the accept edge (no wait states) or on
    // the last WAIT edge. In WAIT the index comes from the latched request.
    assign rd_idx = (state_reg == S_WAIT) ? idx_reg : req_idx;

    // Write-first: a load to the word being captured on the same edge wins.
    assign rd_word = (ld_wr && (ld_idx == rd_idx)) ? ld_data : ram[rd_idx];

    // ---------------------------------------------------------------------
    // Memory write port
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ld_wr) begin
            ram[ld_idx] <= ld_data;
        end
    end

    // ---------------------------------------------------------------------
    // Fetch FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        idx_next      = idx_reg;
        inst_next     = inst_reg;
        err_next      = err_reg;

        case (state_reg)
            S_IDLE, S_RESP: begin
                // Leaving RESP needs resp_ready. In RESP an accept can only
                // happen when resp_ready is high, because req_ready depends on it.
                if ((state_reg == S_RESP) && resp_ready && !accept) begin
                    state_next = S_IDLE;
                end
                if (accept) begin
                    idx_next = req_idx;
                    if (req_fault != 2'b00) begin
                        // Faulting fetch: immediate response, array untouched.
                        state_next = S_RESP;
                        inst_next  = NOP_INST;
                        err_next   = req_fault;
                    end else if (WAIT_STATES == 0) begin
                        state_next = S_RESP;
                        inst_next  = rd_word;
                        err_next   = 2'b00;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = WAIT_INIT;
                    end
                end
            end

            S_WAIT: begin
                if (wait_cnt_reg == 4'd1) begin
                    state_next = S_RESP;
                    inst_next  = rd_word;
                    err_next   = 2'b00;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Fetch FSM: state and response registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 4'd0;
            idx_reg      <= '0;
            inst_reg     <= 32'd0;
            err_reg      <= 2'b00;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            idx_reg      <= idx_next;
            inst_reg     <= inst_next;
            err_reg      <= err_next;
        end
    end

    // ---------------------------------------------------------------------
    // Loader error pulse and completed-fetch counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_err_reg    <= 1'b0;
            fetch_cnt_reg <= 32'd0;
        end else begin
            ld_err_reg <= ld_en & ~ld_wr;
            if ((state_reg == S_RESP) && resp_ready) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
        end
    end

    assign resp_valid = (state_reg == S_RESP);
    assign resp_inst  = inst_reg;
    assign resp_err   = err_reg;
    assign ld_err     = ld_err_reg;
    assign fetch_cnt  = fetch_cnt_reg;

endmodule

// File: tb/tb_inst_mem_seq.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_seq
//
// Directed bench for inst_mem_seq. Three instances share clock, reset and
// loader inputs, and each has its own fetch port:
//   index 0: WAIT_STATES=0, NOP_INST=0
//   index 1: WAIT_STATES=2, NOP_INST=0
//   index 2: WAIT_STATES=3, NOP_INST=0x00000013
// Inputs are driven just after a falling edge. Outputs are sampled on the
// falling edges, away from the rising active edge.
// ---------------------------------------------------------------------------
module tb_inst_mem_seq;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [31:0] req_addr [3];
    logic [2:0]  resp_valid;
    logic [2:0]  resp_ready;
    logic [31:0] resp_inst [3];
    logic [1:0]  resp_err [3];
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [2:0]  ld_err;
    logic [31:0] fetch_cnt [3];

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] NOP2 = 32'h0000_0013;

    inst_mem_seq #(.DEPTH_LOG2(5), .WAIT_STATES(0), .NOP_INST(32'h0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_inst(resp_inst[0]), .resp_err(resp_err[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_err(ld_err[0]), .fetch_cnt(fetch_cnt[0])
    );

    inst_mem_seq #(.DEPTH_LOG2(5), .WAIT_STATES(2), .NOP_INST(32'h0)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_inst(resp_inst[1]), .resp_err(resp_err[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_err(ld_err[1]), .fetch_cnt(fetch_cnt[1])
    );

    inst_mem_seq #(.DEPTH_LOG2(5), .WAIT_STATES(3), .NOP_INST(NOP2)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_inst(resp_inst[2]), .resp_err(resp_err[2]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_err(ld_err[2]), .fetch_cnt(fetch_cnt[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One loader write; returns just after the falling edge that follows it.
    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Single fetch on instance d with an expected latency in edges after
    // accept. The response is held for one cycle and then taken.
    task automatic fetch(input int d, input logic [31:0] a, input int lat,
                         input logic [31:0] exp_inst, input logic [1:0] exp_err,
                         input string tag);
        req_valid[d]  = 1'b1;
        req_addr[d]   = a;
        resp_ready[d] = 1'b0;
        @(negedge clk);
        req_valid[d]  = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check({tag, " wait rv"}, 32'(resp_valid[d]), 32'd0);
            @(negedge clk);
        end
        check({tag, " rv"},   32'(resp_valid[d]), 32'd1);
        check({tag, " inst"}, resp_inst[d], exp_inst);
        check({tag, " err"},  32'(resp_err[d]), 32'(exp_err));
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        check({tag, " done rv"}, 32'(resp_valid[d]), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 3'b000;
        resp_ready = 3'b000;
        ld_en      = 1'b0;
        ld_addr    = 32'd0;
        ld_data    = 32'd0;
        for (int i = 0; i < 3; i++) req_addr[i] = 32'd0;

        // Reset state
        @(negedge clk);
        check("rst rv",   32'(resp_valid[0]), 32'd0);
        check("rst inst", resp_inst[0], 32'd0);
        check("rst err",  32'(resp_err[0]), 32'd0);
        check("rst lderr", 32'(ld_err[0]), 32'd0);
        check("rst cnt",  fetch_cnt[0], 32'd0);
        check("rst rdy",  32'(req_ready[0]), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Program load
        load(32'h0, 32'h0000_2820);
        check("ld ok no err", 32'(ld_err[0]), 32'd0);
        load(32'h4, 32'h8CB1_0000);
        load(32'h8, 32'h1111_1111);
        load(32'hC, 32'hACB3_000C);

        // W=0 single fetch of 0x4
        fetch(0, 32'h4, 0, 32'h8CB1_0000, 2'b00, "w0 f4");
        check("w0 cnt1", fetch_cnt[0], 32'd1);

        // W=3 fetch of 0x0, response held off for 5 cycles
        req_valid[2]  = 1'b1;
        req_addr[2]   = 32'h0;
        resp_ready[2] = 1'b0;
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("w3 rdy in wait", 32'(req_ready[2]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("w3 rv low", 32'(resp_valid[2]), 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            check("w3 rv hold", 32'(resp_valid[2]), 32'd1);
            check("w3 inst hold", resp_inst[2], 32'h0000_2820);
            check("w3 cnt hold", fetch_cnt[2], 32'd0);
            @(negedge clk);
        end
        resp_ready[2] = 1'b1;
        @(negedge clk);
        resp_ready[2] = 1'b0;
        check("w3 rv done", 32'(resp_valid[2]), 32'd0);
        check("w3 cnt1", fetch_cnt[2], 32'd1);

        // Faulting fetches answer in one cycle despite W=3
        fetch(2, 32'h06, 0, NOP2, 2'b01, "mis");
        fetch(2, 32'h80, 0, NOP2, 2'b10, "oor");
        fetch(2, 32'h82, 0, NOP2, 2'b11, "both");
        check("fault cnt", fetch_cnt[2], 32'd4);

        // W=0 back-to-back fetches 0x0, 0x4, 0x8
        resp_ready[0] = 1'b1;
        req_valid[0]  = 1'b1;
        req_addr[0]   = 32'h0;
        @(negedge clk);
        req_addr[0] = 32'h4;
        check("b2b rv0", 32'(resp_valid[0]), 32'd1);
        check("b2b i0", resp_inst[0], 32'h0000_2820);
        check("b2b rdy0", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        req_addr[0] = 32'h8;
        check("b2b i1", resp_inst[0], 32'h8CB1_0000);
        check("b2b rdy1", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("b2b i2", resp_inst[0], 32'h1111_1111);
        @(negedge clk);
        resp_ready[0] = 1'b0;
        check("b2b rv end", 32'(resp_valid[0]), 32'd0);
        check("b2b cnt", fetch_cnt[0], 32'd4);

        // W=2 fetch of 0x8 with a load to 0x8 on the capture edge
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 32'h8;
        ld_data = 32'h1232_0002;
        @(negedge clk);
        ld_en = 1'b0;
        check("coll rv", 32'(resp_valid[1]), 32'd1);
        check("coll inst", resp_inst[1], 32'h1232_0002);
        resp_ready[1] = 1'b1;
        @(negedge clk);
        resp_ready[1] = 1'b0;
        check("coll cnt", fetch_cnt[1], 32'd1);

        // Rejected loads: out of range and misaligned in range
        load(32'h81, 32'hFFFF_FFFF);
        check("ld81 err", 32'(ld_err[0]), 32'd1);
        @(negedge clk);
        check("ld81 err gone", 32'(ld_err[0]), 32'd0);
        load(32'h2, 32'hFFFF_FFFF);
        check("ld2 err", 32'(ld_err[1]), 32'd1);
        fetch(0, 32'h0, 0, 32'h0000_2820, 2'b00, "no wr");

        // Reset during WAIT aborts the fetch; memory survives
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'hC;
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("abort in wait", 32'(req_ready[2]), 32'd0);
        rst = 1'b1;
        #1;
        check("abort rv", 32'(resp_valid[2]), 32'd0);
        check("abort cnt", fetch_cnt[2], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort idle rdy", 32'(req_ready[2]), 32'd1);
        fetch(2, 32'hC, 3, 32'hACB3_000C, 2'b00, "refetch");
        check("refetch cnt", fetch_cnt[2], 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
